control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle control sequencer for the 16-bit bus CPU. It drives the register file's select and enable lines directly and consumes the instruction register output `io`. Each instruction runs as fetch, then decode, then up to two execute steps. It handles the memory read/write handshake, segment selection and stack-pointer stepping.

## Interface
Parameters:
- `WAIT_MAX`, default 255: cycles a memory request may stall before the `bus_err` pulse (the request is still held).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `r`  in  1  reset, synchronous, active-high
- `io`  in  16  instruction register contents
- `mem_ready`  in  1  memory completes the current request this cycle
- `rsto`  out  4  register-select for bus output (0 = none, 1–5 A–E, 6 SP, 7 SB, 8–11 CS/DS/SS/ES)
- `rsti`  out  4  register-select for bus input (same codes)
- `iwe`, `ioe`, `mwe`  out  1 each  instruction-register write, immediate-to-bus output, address-register write
- `pc_oe`, `pc_inc`  out  1 each  program counter to bus; PC increment
- `sp_inc`, `sp_dec`  out  1 each  stack-pointer step
- `mem_rd`, `mem_wr`  out  1 each  memory request, held until `mem_ready`
- `sso`  out  3  segment select for the address path (0 none, 1 CS, 2 DS, 3 SS)
- `instr_done`, `illegal`, `bus_err`  out  1 each  single-cycle pulses
- `halted`  out  1  level; sequencer is in HALT

`rsbo`/`rsbi` are not driven by this block and are tied to 0 at integration.

## Operation
- Encoding:
  - `io[15:14]==2'b11` is LDI: dst = `io[13:10]`, imm = `io[9:0]`.
  - Otherwise op = `io[15:12]`, dst = `io[11:8]`, src = `io[7:4]`.
- Ops: 0 NOP, 1 MOV, 2 LD dst←[src], 3 ST [dst]←src, 4 PUSH src, 5 POP dst, 7 HLT. Ops 6 and 8–B are illegal.
- Register-code legality:
  - A code of 0 or 12–15 in any used field makes the instruction illegal.
  - An illegal instruction pulses `illegal` in DECODE, executes as NOP and still pulses `instr_done`.
- States: FETCH_A → FETCH_M → DECODE → {EX1 → EX2} → FETCH_A. HLT goes DECODE → HALT.
- FETCH_A: `pc_oe=1`, `mwe=1`.
- FETCH_M: `mem_rd=1`, `sso=1`. On `mem_ready`: `iwe=1`, `pc_inc=1`, advance.
- DECODE:
  - MOV: `rsto=src`, `rsti=dst`.
  - LDI: `ioe=1`, `rsti=dst`.
  - LD: `rsto=src`, `mwe=1`.
  - ST: `rsto=dst`, `mwe=1`.
  - PUSH: `rsto=6`, `mwe=1`.
  - POP: `sp_inc=1`.
- EX1:
  - LD: `mem_rd`, `sso=2`, `rsti=dst` when `mem_ready`.
  - ST: `rsto=src`, `mem_wr`, `sso=2`.
  - PUSH: `rsto=src`, `mem_wr`, `sso=3`.
  - POP: `rsto=6`, `mwe=1`.
- EX2:
  - PUSH: `sp_dec=1`.
  - POP: `mem_rd`, `sso=3`, `rsti=dst` when `mem_ready`.
- HALT: all strobes 0, `halted=1`. Left only by reset.
- A memory state with `mem_ready=0` holds the state and all of its outputs unchanged. Any `rsti` or `iwe` write happens only in the `mem_ready` cycle.
- `bus_err`: pulses once when the stall counter reaches `WAIT_MAX`. The counter saturates; the request stays asserted.
- Outputs are a combinational decode of state plus the opcode fields latched in DECODE. The opcode is latched so that `io` changes after DECODE are ignored.

## Timing
- Reset:
  - While `r=1`, all outputs are 0.
  - The first cycle after `r` falls is FETCH_A.
  - Reset during a held memory request drops the request the next cycle; no write strobe occurs.
- Latency with zero wait:
  - NOP, MOV, LDI, illegal: 3 cycles.
  - LD, ST: 4 cycles.
  - PUSH, POP: 5 cycles.
  - Each wait cycle adds 1.
- `instr_done` pulses in the final cycle of each instruction, concurrent with the last strobe.
- `mem_ready` outside a memory state is ignored.
- At most one of `pc_oe`, `ioe`, or nonzero `rsto` is active in any cycle; this is a verification assertion.

## Structure
- Shared package `cpu_pkg`:
  - state enum
  - opcode constants
  - register codes `REG_A`..`REG_ES` (1–11)
  - segment codes `SEG_NONE/CS/DS/SS`
- One sub-module, `instr_decode`: combinational field extraction, LDI detect and legality check. The sequencer holds the FSM, opcode latch and stall counter.

## Test plan
- Reset, then `io=0x1320` (MOV C,B) with `mem_ready=1` → FETCH_A, FETCH_M, then DECODE with `rsto=2`, `rsti=3`, `instr_done=1`; cycle 4 is FETCH_A.
- `io=0xC7FF` (LDI code 1, 0x3FF) → DECODE `ioe=1`, `rsti=1`; `io=0xFC00` → `rsti=15` illegal, `illegal` pulse, no `ioe`.
- LD A,[B] with `mem_ready` low 3 cycles in EX1 → `mem_rd`, `sso=2` held 4 cycles, `rsti=1` only in the last; total 7 cycles.
- PUSH C (`0x4030`) → DECODE `rsto=6`/`mwe`, EX1 `rsto=3`/`mem_wr`/`sso=3`, EX2 `sp_dec`; POP D mirrors, starting with `sp_inc`.
- HLT (`0x7000`) → `halted=1` indefinitely; assert `r` → outputs 0, then FETCH_A.
- `WAIT_MAX=4`, `mem_ready` stuck low in FETCH_M → one `bus_err` pulse on stall cycle 4; assert `r` mid-stall → `mem_rd` drops next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit bus CPU control path: sequencer states,
// opcodes, register and segment codes, and the register-code legality helper.
package cpu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH_A = 3'd0;
  localparam state_t ST_FETCH_M = 3'd1;
  localparam state_t ST_DECODE  = 3'd2;
  localparam state_t ST_EX1     = 3'd3;
  localparam state_t ST_EX2     = 3'd4;
  localparam state_t ST_HALT    = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_PUSH = 4'h4;
  localparam logic [3:0] OP_POP  = 4'h5;
  localparam logic [3:0] OP_HLT  = 4'h7;

  // Effective instruction class; illegal encodings collapse to K_NOP.
  typedef enum logic [2:0] {
    K_NOP, K_MOV, K_LDI, K_LD, K_ST, K_PUSH, K_POP, K_HLT
  } kind_t;

  localparam logic [3:0] REG_NONE = 4'd0;
  localparam logic [3:0] REG_A    = 4'd1;
  localparam logic [3:0] REG_B    = 4'd2;
  localparam logic [3:0] REG_C    = 4'd3;
  localparam logic [3:0] REG_D    = 4'd4;
  localparam logic [3:0] REG_E    = 4'd5;
  localparam logic [3:0] REG_SP   = 4'd6;
  localparam logic [3:0] REG_SB   = 4'd7;
  localparam logic [3:0] REG_CS   = 4'd8;
  localparam logic [3:0] REG_DS   = 4'd9;
  localparam logic [3:0] REG_SS   = 4'd10;
  localparam logic [3:0] REG_ES   = 4'd11;

  localparam logic [2:0] SEG_NONE = 3'd0;
  localparam logic [2:0] SEG_CS   = 3'd1;
  localparam logic [2:0] SEG_DS   = 3'd2;
  localparam logic [2:0] SEG_SS   = 3'd3;

  function automatic logic reg_ok(input logic [3:0] code);
    return (code >= REG_A) && (code <= REG_ES);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction-register decode: field extraction, LDI detection
// and legality check of the opcode and every register field it uses.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] io,
  output kind_t       kind,
  output logic [3:0]  dst,
  output logic [3:0]  src,
  output logic        illegal
);

  logic  is_ldi;
  logic  ok;
  kind_t raw;
  logic  unused_low;

  assign unused_low = ^io[3:0];

  always_comb begin
    is_ldi = (io[15:14] == 2'b11);
    dst    = is_ldi ? io[13:10] : io[11:8];
    src    = io[7:4];
    raw    = K_NOP;
    ok     = 1'b1;
    if (is_ldi) begin
      raw = K_LDI;
      ok  = reg_ok(dst);
    end else begin
      case (io[15:12])
        OP_NOP:  raw = K_NOP;
        OP_MOV:  begin raw = K_MOV;  ok = reg_ok(dst) && reg_ok(src); end
        OP_LD:   begin raw = K_LD;   ok = reg_ok(dst) && reg_ok(src); end
        OP_ST:   begin raw = K_ST;   ok = reg_ok(dst) && reg_ok(src); end
        OP_PUSH: begin raw = K_PUSH; ok = reg_ok(src); end
        OP_POP:  begin raw = K_POP;  ok = reg_ok(dst); end
        OP_HLT:  raw = K_HLT;
        default: ok = 1'b0;
      endcase
    end
    illegal = !ok;
    kind    = ok ? raw : K_NOP;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute FSM with memory
// handshake, opcode latch taken in DECODE and a saturating stall counter.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        r,
  input  logic [15:0] io,
  input  logic        mem_ready,
  output logic [3:0]  rsto,
  output logic [3:0]  rsti,
  output logic        iwe,
  output logic        ioe,
  output logic        mwe,
  output logic        pc_oe,
  output logic        pc_inc,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  sso,
  output logic        instr_done,
  output logic        illegal,
  output logic        bus_err,
  output logic        halted
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);
  localparam logic [CW-1:0] CNT_ERR = CW'(WAIT_MAX - 1);

  state_t        state, next_state;
  kind_t         kind_q;
  logic [3:0]    dst_q, src_q;
  logic [CW-1:0] stall_cnt;

  kind_t         d_kind;
  logic [3:0]    d_dst, d_src;
  logic          d_illegal;
  logic          mem_state, stall;

  instr_decode u_decode (
    .io      (io),
    .kind    (d_kind),
    .dst     (d_dst),
    .src     (d_src),
    .illegal (d_illegal)
  );

  always_comb begin
    mem_state = 1'b0;
    case (state)
      ST_FETCH_M: mem_state = 1'b1;
      ST_EX1:     mem_state = (kind_q == K_LD) || (kind_q == K_ST) || (kind_q == K_PUSH);
      ST_EX2:     mem_state = (kind_q == K_POP);
      default:    mem_state = 1'b0;
    endcase
    stall = mem_state && !mem_ready;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH_A: next_state = ST_FETCH_M;
      ST_FETCH_M: if (mem_ready) next_state = ST_DECODE;
      ST_DECODE: begin
        case (d_kind)
          K_NOP, K_MOV, K_LDI: next_state = ST_FETCH_A;
          K_HLT:               next_state = ST_HALT;
          default:             next_state = ST_EX1;
        endcase
      end
      ST_EX1: begin
        case (kind_q)
          K_LD, K_ST: if (mem_ready) next_state = ST_FETCH_A;
          K_PUSH:     if (mem_ready) next_state = ST_EX2;
          K_POP:      next_state = ST_EX2;
          default:    next_state = ST_FETCH_A;
        endcase
      end
      ST_EX2: begin
        if (kind_q != K_POP || mem_ready) next_state = ST_FETCH_A;
      end
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_FETCH_A;
    endcase
  end

  // The stall counter restarts for every request and saturates so bus_err fires once.
  always_ff @(posedge clk) begin
    if (r) begin
      state     <= ST_FETCH_A;
      kind_q    <= K_NOP;
      dst_q     <= REG_NONE;
      src_q     <= REG_NONE;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_DECODE) begin
        kind_q <= d_kind;
        dst_q  <= d_dst;
        src_q  <= d_src;
      end
      if (stall) begin
        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CW'(1);
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  always_comb begin
    rsto       = REG_NONE;
    rsti       = REG_NONE;
    iwe        = 1'b0;
    ioe        = 1'b0;
    mwe        = 1'b0;
    pc_oe      = 1'b0;
    pc_inc     = 1'b0;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    sso        = SEG_NONE;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    halted     = 1'b0;
    if (!r) begin
      case (state)
        ST_FETCH_A: begin
          pc_oe = 1'b1;
          mwe   = 1'b1;
        end
        ST_FETCH_M: begin
          mem_rd = 1'b1;
          sso    = SEG_CS;
          if (mem_ready) begin
            iwe    = 1'b1;
            pc_inc = 1'b1;
          end
        end
        // DECODE drives from the live decode; later states use the latched fields.
        ST_DECODE: begin
          illegal = d_illegal;
          case (d_kind)
            K_MOV:  begin rsto = d_src; rsti = d_dst; instr_done = 1'b1; end
            K_LDI:  begin ioe = 1'b1; rsti = d_dst; instr_done = 1'b1; end
            K_LD:   begin rsto = d_src; mwe = 1'b1; end
            K_ST:   begin rsto = d_dst; mwe = 1'b1; end
            K_PUSH: begin rsto = REG_SP; mwe = 1'b1; end
            K_POP:  sp_inc = 1'b1;
            default: instr_done = 1'b1;
          endcase
        end
        ST_EX1: begin
          case (kind_q)
            K_LD: begin
              mem_rd = 1'b1;
              sso    = SEG_DS;
              if (mem_ready) begin
                rsti       = dst_q;
                instr_done = 1'b1;
              end
            end
            K_ST: begin
              rsto       = src_q;
              mem_wr     = 1'b1;
              sso        = SEG_DS;
              instr_done = mem_ready;
            end
            K_PUSH: begin
              rsto   = src_q;
              mem_wr = 1'b1;
              sso    = SEG_SS;
            end
            K_POP: begin
              rsto = REG_SP;
              mwe  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_EX2: begin
          case (kind_q)
            K_PUSH: begin
              sp_dec     = 1'b1;
              instr_done = 1'b1;
            end
            K_POP: begin
              mem_rd = 1'b1;
              sso    = SEG_SS;
              if (mem_ready) begin
                rsti       = dst_q;
                instr_done = 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
      bus_err = stall && (stall_cnt == CNT_ERR);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each instruction is expanded by a cycle-list reference
// model into expected strobes, then replayed against the sequencer.
module tb_control_sequencer;

  localparam int WAIT_MAX = 4;

  typedef struct packed {
    logic [3:0] rsto;
    logic [3:0] rsti;
    logic [2:0] sso;
    logic       iwe, ioe, mwe, pc_oe, pc_inc, sp_inc, sp_dec;
    logic       mem_rd, mem_wr, done, illegal, bus_err, halted;
  } outs_t;

  typedef struct {
    outs_t       o;
    outs_t       mask;
    logic        rdy;
    logic [15:0] iov;
  } step_t;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic [15:0] io = 16'h0;
  logic        mem_ready = 1'b0;
  logic [3:0]  rsto, rsti;
  logic        iwe, ioe, mwe, pc_oe, pc_inc, sp_inc, sp_dec, mem_rd, mem_wr;
  logic [2:0]  sso;
  logic        instr_done, illegal, bus_err, halted;

  int    n_checks = 0;
  int    n_fail = 0;
  step_t steps[$];

  control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .r(r), .io(io), .mem_ready(mem_ready),
    .rsto(rsto), .rsti(rsti), .iwe(iwe), .ioe(ioe), .mwe(mwe),
    .pc_oe(pc_oe), .pc_inc(pc_inc), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .sso(sso), .instr_done(instr_done),
    .illegal(illegal), .bus_err(bus_err), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic regOk(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd11);
  endfunction

  task automatic applyStimulus(input logic rst, input logic [15:0] iv, input logic rdy);
    r = rst;
    io = iv;
    mem_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input outs_t exp, input outs_t mask);
    outs_t act;
    act = '0;
    act.rsto = rsto;     act.rsti = rsti;       act.sso = sso;
    act.iwe = iwe;       act.ioe = ioe;         act.mwe = mwe;
    act.pc_oe = pc_oe;   act.pc_inc = pc_inc;   act.sp_inc = sp_inc;
    act.sp_dec = sp_dec; act.mem_rd = mem_rd;   act.mem_wr = mem_wr;
    act.done = instr_done; act.illegal = illegal; act.bus_err = bus_err;
    act.halted = halted;
    n_checks++;
    assert ((act & mask) === (exp & mask)) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %06h expected %06h", tag, act & mask, exp & mask);
    end
    n_checks++;
    assert ((32'(pc_oe) + 32'(ioe) + 32'(rsto != 4'd0)) <= 1) else begin
      n_fail++;
      $error("[TB] FAIL %s_bus_excl: observed pc_oe=%0b ioe=%0b rsto=%0d expected one driver at most",
             tag, pc_oe, ioe, rsto);
    end
  endtask

  task automatic pushStep(input outs_t o, input logic rdy, input logic [15:0] iv, input outs_t mask);
    step_t s;
    s.o = o; s.rdy = rdy; s.iov = iv; s.mask = mask;
    steps.push_back(s);
  endtask

  // A memory request: 'waits' stalled cycles then the completing cycle.
  task automatic addMem(input outs_t base, input outs_t on_ready, input int waits,
                        input logic hold, input logic [15:0] iv);
    outs_t o;
    for (int k = 1; k <= waits; k++) begin
      o = base;
      o.bus_err = (k == WAIT_MAX);
      pushStep(o, 1'b0, hold ? iv : 16'($urandom), '1);
    end
    o = base | on_ready;
    pushStep(o, 1'b1, hold ? iv : 16'($urandom), '1);
  endtask

  task automatic addPlain(input outs_t o, input logic hold, input logic [15:0] iv);
    pushStep(o, 1'($urandom), hold ? iv : 16'($urandom), '1);
  endtask

  task automatic buildFetch(input logic [15:0] iv, input int wf);
    outs_t o, x;
    o = '0; o.pc_oe = 1'b1; o.mwe = 1'b1;
    addPlain(o, 1'b1, iv);
    o = '0; o.mem_rd = 1'b1; o.sso = 3'd1;
    x = '0; x.iwe = 1'b1; x.pc_inc = 1'b1;
    addMem(o, x, wf, 1'b1, iv);
  endtask

  task automatic buildInstr(input logic [15:0] iv, input int wf, input int wm);
    outs_t o, x;
    logic ldi, ok;
    logic [3:0] op, dst, src;
    ldi = (iv[15:14] == 2'b11);
    op  = iv[15:12];
    dst = ldi ? iv[13:10] : iv[11:8];
    src = iv[7:4];
    if (ldi) ok = regOk(dst);
    else case (op)
      4'd0, 4'd7:       ok = 1'b1;
      4'd1, 4'd2, 4'd3: ok = regOk(dst) && regOk(src);
      4'd4:             ok = regOk(src);
      4'd5:             ok = regOk(dst);
      default:          ok = 1'b0;
    endcase
    buildFetch(iv, wf);
    o = '0;
    if (!ok) begin
      o.illegal = 1'b1; o.done = 1'b1;
      addPlain(o, 1'b1, iv);
    end else if (ldi) begin
      o.ioe = 1'b1; o.rsti = dst; o.done = 1'b1;
      addPlain(o, 1'b1, iv);
    end else case (op)
      4'd1: begin
        o.rsto = src; o.rsti = dst; o.done = 1'b1;
        addPlain(o, 1'b1, iv);
      end
      4'd2: begin
        o.rsto = src; o.mwe = 1'b1; addPlain(o, 1'b1, iv);
        o = '0; o.mem_rd = 1'b1; o.sso = 3'd2;
        x = '0; x.rsti = dst; x.done = 1'b1;
        addMem(o, x, wm, 1'b0, iv);
      end
      4'd3: begin
        o.rsto = dst; o.mwe = 1'b1; addPlain(o, 1'b1, iv);
        o = '0; o.rsto = src; o.mem_wr = 1'b1; o.sso = 3'd2;
        x = '0; x.done = 1'b1;
        addMem(o, x, wm, 1'b0, iv);
      end
      4'd4: begin
        o.rsto = 4'd6; o.mwe = 1'b1; addPlain(o, 1'b1, iv);
        o = '0; o.rsto = src; o.mem_wr = 1'b1; o.sso = 3'd3;
        addMem(o, '0, wm, 1'b0, iv);
        o = '0; o.sp_dec = 1'b1; o.done = 1'b1;
        addPlain(o, 1'b0, iv);
      end
      4'd5: begin
        o.sp_inc = 1'b1; addPlain(o, 1'b1, iv);
        o = '0; o.rsto = 4'd6; o.mwe = 1'b1; addPlain(o, 1'b0, iv);
        o = '0; o.mem_rd = 1'b1; o.sso = 3'd3;
        x = '0; x.rsti = dst; x.done = 1'b1;
        addMem(o, x, wm, 1'b0, iv);
      end
      default: begin
        o.done = 1'b1;
        addPlain(o, 1'b1, iv);
      end
    endcase
  endtask

  task automatic runSteps(input string tag, input int limit);
    step_t s;
    int n = 0;
    while (steps.size() > 0 && n < limit) begin
      s = steps.pop_front();
      @(negedge clk);
      applyStimulus(1'b0, s.iov, s.rdy);
      #1;
      checkOutput($sformatf("%s_c%0d", tag, n), s.o, s.mask);
      n++;
    end
    steps.delete();
  endtask

  task automatic doReset(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 16'($urandom), 1'($urandom));
      #1;
      checkOutput($sformatf("%s_c%0d", tag, i), '0, '1);
    end
  endtask

  function automatic logic [3:0] randReg();
    if ($urandom_range(0, 5) == 0) return 4'($urandom);
    return 4'($urandom_range(1, 11));
  endfunction

  function automatic logic [15:0] genInstr();
    logic [3:0] op;
    logic [15:0] v;
    case ($urandom_range(0, 8))
      0: op = 4'd0;
      1: op = 4'd1;
      2: op = 4'd2;
      3: op = 4'd3;
      4: op = 4'd4;
      5: op = 4'd5;
      6: op = 4'($urandom_range(8, 11));
      default: op = 4'd6;
    endcase
    v = {op, randReg(), randReg(), 4'($urandom)};
    if ($urandom_range(0, 7) == 0) v = {2'b11, randReg(), 10'($urandom)};
    if ($urandom_range(0, 3) == 0 && op == 4'd6) v[15:12] = 4'd1;
    return v;
  endfunction

  function automatic int randWait();
    if ($urandom_range(0, 3) == 0) return $urandom_range(1, 6);
    return 0;
  endfunction

  initial begin
    outs_t o;
    doReset("reset", 3);

    buildInstr(16'h1320, 0, 0); runSteps("mov_cb", 99);
    buildInstr(16'hC7FF, 0, 0); runSteps("ldi_a", 99);
    buildInstr(16'hFC00, 0, 0); runSteps("ldi_illegal", 99);
    buildInstr(16'h2120, 0, 3); runSteps("ld_wait3", 99);
    buildInstr(16'h4030, 0, 0); runSteps("push_c", 99);
    buildInstr(16'h5400, 0, 0); runSteps("pop_d", 99);
    buildInstr(16'h4050, 2, 1); runSteps("push_e_wait", 99);
    buildInstr(16'h5100, 1, 2); runSteps("pop_a_wait", 99);
    buildInstr(16'h3120, 0, 5); runSteps("st_buserr", 99);
    buildInstr(16'h1020, 0, 0); runSteps("mov_dst0", 99);

    for (int i = 0; i < 150; i++) begin
      buildInstr(genInstr(), randWait(), randWait());
      runSteps($sformatf("rand%0d", i), 99);
    end

    // HLT: decode cycle done flag is not compared, then halted holds.
    buildFetch(16'h7000, 0);
    o = '0; o.done = 1'b1;
    pushStep('0, 1'b1, 16'h7000, ~o);
    for (int i = 0; i < 6; i++) begin
      o = '0; o.halted = 1'b1;
      pushStep(o, 1'($urandom), 16'($urandom), '1);
    end
    runSteps("hlt", 99);
    doReset("hlt_reset", 2);
    buildInstr(16'h1320, 0, 0); runSteps("after_hlt", 99);

    buildInstr(16'h1320, 6, 0); runSteps("fetch_stall", 7);
    doReset("stall_reset", 2);
    buildInstr(16'h3120, 0, 4); runSteps("st_stall", 5);
    doReset("st_reset", 2);
    buildInstr(16'h1230, 0, 0); runSteps("after_reset", 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
